// File: rtl/qsram_edge_sequencer_pkg.sv
// Shared definitions for the QSRAM edge sequencer.
// State encoding and strobe bit positions.
package qsram_edge_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_STROBE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4,
        S_RARM    = 3'd5,
        S_RSTROBE = 3'd6
    } state_t;

    localparam int STB_READ    = 0;
    localparam int STB_WRITE   = 1;
    localparam int STB_REFRESH = 2;
    localparam int STB_W       = 3;

endpackage

// File: rtl/qsram_edge_sequencer_refresh_timer.sv
// Tick counter that schedules refreshes.
// Owns the pending flag and the sticky overrun flag.
module qsram_edge_sequencer_refresh_timer #(
    parameter int REFRESH_TICKS = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic clr,
    output logic pending,
    output logic overrun
);

    localparam int CW = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap = tick && (cnt == CW'(REFRESH_TICKS - 1));

    // count ticks; a wrap raises pending and flags overrun if unserviced
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (tick)
                cnt <= wrap ? '0 : cnt + CW'(1);
            if (wrap)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
            if (wrap && pending && !clr)
                overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/qsram_edge_sequencer.sv
// Sequences read/write/refresh strobes to a QSRAM row bank,
// paced by TickEdge; refresh has priority over requests.
module qsram_edge_sequencer
    import qsram_edge_sequencer_pkg::*;
#(
    parameter int ROWS          = 16,
    parameter int ADDR_W        = 4,
    parameter int DATA_W        = 8,
    parameter int REFRESH_TICKS = 64
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              TickEdge,
    input  logic              ReqValid,
    input  logic              ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqData,
    output logic              ReqReady,
    output logic              RspValid,
    output logic [DATA_W-1:0] RspData,
    output logic [ADDR_W-1:0] CellRow,
    output logic [DATA_W-1:0] CellWriteData,
    input  logic [DATA_W-1:0] CellReadData,
    output logic              ReadEdge,
    output logic              WriteEdge,
    output logic              RefreshEdge,
    output logic              RefreshOverrun
);

    state_t             state;
    logic               live;
    logic               wr;
    logic [ADDR_W-1:0]  ptr;
    logic [STB_W-1:0]   stb;
    logic               pending;
    logic               idle_like;

    // completion states already accept the next request
    assign idle_like = (state == S_IDLE) || (state == S_CAPTURE)
                    || (state == S_DONE);
    assign ReqReady  = live && idle_like && !pending;

    assign ReadEdge    = stb[STB_READ];
    assign WriteEdge   = stb[STB_WRITE];
    assign RefreshEdge = stb[STB_REFRESH];

    qsram_edge_sequencer_refresh_timer #(
        .REFRESH_TICKS(REFRESH_TICKS)
    ) u_timer (
        .clk    (Clock),
        .rst    (Reset),
        .tick   (TickEdge),
        .clr    (state == S_RSTROBE),
        .pending(pending),
        .overrun(RefreshOverrun)
    );

    // main sequencer: state, latched request, row pointer, registered outputs
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state         <= S_IDLE;
            live          <= 1'b0;
            wr            <= 1'b0;
            ptr           <= '0;
            stb           <= '0;
            RspValid      <= 1'b0;
            RspData       <= '0;
            CellRow       <= '0;
            CellWriteData <= '0;
        end else begin
            live     <= 1'b1;
            stb      <= '0;
            RspValid <= 1'b0;
            unique case (state)
                S_IDLE, S_CAPTURE, S_DONE: begin
                    if (pending) begin
                        state   <= S_RARM;
                        CellRow <= ptr;
                    end else if (ReqValid && live) begin
                        state         <= S_ARM;
                        wr            <= ReqWrite;
                        CellRow       <= ReqAddr;
                        CellWriteData <= ReqData;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ARM: begin
                    if (TickEdge) begin
                        state          <= S_STROBE;
                        stb[STB_READ]  <= !wr;
                        stb[STB_WRITE] <= wr;
                    end
                end
                S_STROBE: begin
                    RspValid <= 1'b1;
                    if (wr) begin
                        state <= S_DONE;
                    end else begin
                        state   <= S_CAPTURE;
                        RspData <= CellReadData;
                    end
                end
                S_RARM: begin
                    if (TickEdge) begin
                        state            <= S_RSTROBE;
                        stb[STB_REFRESH] <= 1'b1;
                    end
                end
                S_RSTROBE: begin
                    state <= S_IDLE;
                    ptr   <= (ptr == ADDR_W'(ROWS - 1)) ? '0 : ptr + ADDR_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qsram_edge_sequencer.sv
// Directed bench for qsram_edge_sequencer.
// Instance a: default sizing; instance b: 4 rows, refresh every 4 ticks.
module tb_qsram_edge_sequencer;

    logic Clock = 1'b0;
    logic Reset;
    logic TickEdge;

    always #5 Clock = ~Clock;

    logic       a_valid, a_write, a_ready, a_rspv;
    logic [3:0] a_addr, a_row;
    logic [7:0] a_data, a_rspd, a_wdat, a_rdat;
    logic       a_rd, a_wr, a_rf, a_ovr;

    logic       b_valid, b_write, b_ready, b_rspv;
    logic [1:0] b_addr, b_row;
    logic [7:0] b_data, b_rspd, b_wdat, b_rdat;
    logic       b_rd, b_wr, b_rf, b_ovr;

    qsram_edge_sequencer #(
        .ROWS(16), .ADDR_W(4), .DATA_W(8), .REFRESH_TICKS(64)
    ) dut_a (
        .Clock(Clock), .Reset(Reset), .TickEdge(TickEdge),
        .ReqValid(a_valid), .ReqWrite(a_write), .ReqAddr(a_addr),
        .ReqData(a_data), .ReqReady(a_ready), .RspValid(a_rspv),
        .RspData(a_rspd), .CellRow(a_row), .CellWriteData(a_wdat),
        .CellReadData(a_rdat), .ReadEdge(a_rd), .WriteEdge(a_wr),
        .RefreshEdge(a_rf), .RefreshOverrun(a_ovr)
    );

    qsram_edge_sequencer #(
        .ROWS(4), .ADDR_W(2), .DATA_W(8), .REFRESH_TICKS(4)
    ) dut_b (
        .Clock(Clock), .Reset(Reset), .TickEdge(TickEdge),
        .ReqValid(b_valid), .ReqWrite(b_write), .ReqAddr(b_addr),
        .ReqData(b_data), .ReqReady(b_ready), .RspValid(b_rspv),
        .RspData(b_rspd), .CellRow(b_row), .CellWriteData(b_wdat),
        .CellReadData(b_rdat), .ReadEdge(b_rd), .WriteEdge(b_wr),
        .RefreshEdge(b_rf), .RefreshOverrun(b_ovr)
    );

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [1:0] rows_q[$];
    logic       mon_en = 1'b0;

    // record which row each refresh strobe targeted
    always @(negedge Clock)
        if (mon_en && b_rf)
            rows_q.push_back(b_row);

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        TickEdge = 1'b0;
        step(2);
        Reset = 1'b0;
        step(1);
    endtask

    task automatic tick_b(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            TickEdge = 1'b1;
            step(1);
            TickEdge = 1'b0;
            step(gap);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [1:0] exp_rows [5];
        exp_rows = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        Reset = 1'b1; TickEdge = 1'b0;
        a_valid = 0; a_write = 0; a_addr = '0; a_data = '0; a_rdat = '0;
        b_valid = 0; b_write = 0; b_addr = '0; b_data = '0; b_rdat = '0;

        // 1: reset state
        step(3);
        check("rst_ctl", {a_ready, a_rspv, a_rd, a_wr, a_rf, a_ovr}, 0);
        check("rst_dat", {a_row, a_wdat, a_rspd}, 0);
        check("rst_b", {b_ready, b_rspv, b_rd, b_wr, b_rf, b_ovr, b_row}, 0);
        Reset = 1'b0;
        step(1);
        check("rdy_after_rst", a_ready, 1);

        // 2: write row 5, tick two cycles after the handshake
        a_valid = 1; a_write = 1; a_addr = 4'd5; a_data = 8'hA5;
        step(1);
        a_valid = 0;
        check("wr_arm", {a_ready, a_row, a_wdat}, {1'b0, 4'd5, 8'hA5});
        step(1);
        TickEdge = 1'b1;
        step(1);
        TickEdge = 1'b0;
        check("wr_strobe", {a_wr, a_rd, a_rspv}, 3'b100);
        step(1);
        check("wr_done", {a_wr, a_rspv, a_ready}, 3'b011);
        check("wr_rspd_kept", a_rspd, 8'h00);
        step(1);
        check("wr_rsp_pulse", a_rspv, 0);

        // 3: read row 3; tick with the handshake must not arm
        a_valid = 1; a_write = 0; a_addr = 4'd3; a_data = 8'hFF;
        TickEdge = 1'b1;
        step(1);
        a_valid = 0; TickEdge = 1'b0;
        check("rd_no_early", {a_rd, a_wr, a_row}, {2'b00, 4'd3});
        TickEdge = 1'b1;
        step(1);
        TickEdge = 1'b0;
        check("rd_strobe", {a_rd, a_wr, a_rspv}, 3'b100);
        a_rdat = 8'h3C;
        step(1);
        a_rdat = 8'h00;
        check("rd_rsp", {a_rspv, a_rd, a_rspd}, {2'b10, 8'h3C});
        step(1);
        check("rd_rsp_hold", {a_rspv, a_rspd}, {1'b0, 8'h3C});

        // 4: free-running refresh on b, rows wrap back to 0
        do_reset();
        mon_en = 1'b1;
        tick_b(21, 3);
        step(2);
        mon_en = 1'b0;
        check("ref_count", rows_q.size(), 5);
        for (int i = 0; i < rows_q.size() && i < 5; i++)
            check($sformatf("ref_row%0d", i), rows_q[i], exp_rows[i]);
        check("ref_no_ovr", {b_ovr, b_ready}, 2'b01);

        // 5: refresh due blocks a pending write until it issues
        do_reset();
        tick_b(4, 1);
        check("ref_due_rdy", b_ready, 0);
        b_valid = 1; b_write = 1; b_addr = 2'd1; b_data = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("rdy_hold", b_ready, 0);
        end
        check("rarm_row", b_row, 2'd0);
        TickEdge = 1'b1;
        step(1);
        TickEdge = 1'b0;
        check("ref_edge", {b_rf, b_ready}, 2'b10);
        step(1);
        check("rdy_after_ref", {b_rf, b_ready}, 2'b01);
        step(1);
        b_valid = 0;
        check("req_arm", {b_row, b_wdat, b_ready}, {2'd1, 8'h5A, 1'b0});
        TickEdge = 1'b1;
        step(1);
        TickEdge = 1'b0;
        check("req_wedge", {b_wr, b_rd, b_rf}, 3'b100);
        step(1);
        check("req_rsp", b_rspv, 1);

        // 6: continuous ticks with a read held force an overrun
        do_reset();
        b_valid = 1; b_write = 0; b_addr = 2'd2; b_rdat = 8'h99;
        TickEdge = 1'b1;
        n = 0;
        while (!b_ovr && n < 20) begin
            step(1);
            n++;
        end
        TickEdge = 1'b0;
        check("ovr_set", b_ovr, 1);
        check("ovr_cycle", n, 8);
        step(5);
        check("ovr_sticky", b_ovr, 1);
        check("ovr_arm", {b_row, b_ready}, {2'd2, 1'b0});
        TickEdge = 1'b1;
        step(1);
        TickEdge = 1'b0;
        check("abort_strobe", b_rd, 1);
        Reset = 1'b1; b_valid = 0;
        step(1);
        check("abort_rst", {b_rspv, b_rd, b_ovr}, 3'b000);
        Reset = 1'b0;
        step(1);
        check("abort_after", {b_rspv, b_rd, b_rf}, 3'b000);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

endmodule
